// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: registers the X->M boundary, runs a load/store unit
// against a req/gnt/rvalid data-memory port and formats the write-back value.
module mem_stage_lsu #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_x,
  output logic              ready_x,
  input  logic [31:0]       PC_x,
  input  logic [31:0]       alu_x,
  input  logic [31:0]       rs2_x,
  input  logic [31:0]       inst_x,
  output logic              valid_m,
  output logic [31:0]       inst_m,
  output logic [31:0]       wb_m,
  output logic              misalign_m,
  output logic              bus_err_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  // Access size comes from funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic sz_byte(input logic [1:0] sz);
    return (sz == 2'b00);
  endfunction

  function automatic logic sz_half(input logic [1:0] sz);
    return (sz == 2'b01);
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz_half(sz) && a[0]) || (sz[1] && (a != 2'b00));
  endfunction

  state_t           r_state;
  logic             r_m_valid;
  logic [31:0]      r_pc_m;
  logic [31:0]      r_alu_m;
  logic [31:0]      r_rs2_m;
  logic [31:0]      r_inst_m;
  logic [31:0]      r_ld_buf;
  logic             r_misalign;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_cnt;

  logic        w_ls_x;
  logic        w_misalign_x;
  logic        w_mem_ok_x;
  logic        w_complete;
  logic        w_accept;
  logic        w_timeout;
  logic [6:0]  w_op_m;
  logic [2:0]  w_f3_m;
  logic        w_is_load_m;
  logic        w_is_store_m;
  logic        w_is_jump_m;
  logic        w_byte_m;
  logic        w_half_m;
  logic [3:0]  w_be_m;
  logic [31:0] w_wdata_m;
  logic [31:0] w_lane;
  logic [31:0] w_load_val;
  logic [31:0] w_wb;

  // X-side decode, only needed to pick the state entered on accept.
  assign w_ls_x       = (inst_x[6:0] == OP_LOAD) || (inst_x[6:0] == OP_STORE);
  assign w_misalign_x = w_ls_x && misaligned(inst_x[13:12], alu_x[1:0]);
  assign w_mem_ok_x   = w_ls_x && !w_misalign_x;

  assign w_complete = r_m_valid && ((r_state == S_IDLE) || (r_state == S_RESP));
  assign ready_x    = !r_m_valid || w_complete;
  assign w_accept   = valid_x && ready_x;
  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

  assign w_op_m       = r_inst_m[6:0];
  assign w_f3_m       = r_inst_m[14:12];
  assign w_is_load_m  = (w_op_m == OP_LOAD);
  assign w_is_store_m = (w_op_m == OP_STORE);
  assign w_is_jump_m  = (w_op_m == OP_JAL) || (w_op_m == OP_JALR);
  assign w_byte_m     = sz_byte(w_f3_m[1:0]);
  assign w_half_m     = sz_half(w_f3_m[1:0]);

  always_comb begin
    w_be_m    = 4'b1111;
    w_wdata_m = r_rs2_m;
    if (w_byte_m) begin
      w_be_m    = 4'b0001 << r_alu_m[1:0];
      w_wdata_m = {4{r_rs2_m[7:0]}};
    end else if (w_half_m) begin
      w_be_m    = 4'b0011 << {r_alu_m[1], 1'b0};
      w_wdata_m = {2{r_rs2_m[15:0]}};
    end
  end

  // Accesses are aligned by construction, so one byte shift serves every size.
  always_comb begin
    w_lane     = r_ld_buf >> {r_alu_m[1:0], 3'b000};
    w_load_val = w_lane;
    if (w_byte_m)
      w_load_val = {{24{!w_f3_m[2] && w_lane[7]}}, w_lane[7:0]};
    else if (w_half_m)
      w_load_val = {{16{!w_f3_m[2] && w_lane[15]}}, w_lane[15:0]};
    w_wb = r_alu_m;
    if (w_is_load_m && !r_misalign && !r_bus_err)
      w_wb = w_load_val;
    else if (w_is_jump_m)
      w_wb = r_pc_m + 32'd4;
  end

  // NOTE: state uses non-blocking assignments only; every register, including
  // the load buffer, is a flop with a reset value rather than an array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_m_valid  <= 1'b0;
      r_pc_m     <= '0;
      r_alu_m    <= '0;
      r_rs2_m    <= '0;
      r_inst_m   <= NOP;
      r_ld_buf   <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_m_valid  <= 1'b1;
      r_pc_m     <= PC_x;
      r_alu_m    <= alu_x;
      r_rs2_m    <= rs2_x;
      r_inst_m   <= inst_x;
      r_misalign <= w_misalign_x;
      r_bus_err  <= 1'b0;
      r_cnt      <= '0;
      r_state    <= w_mem_ok_x ? S_REQ : S_IDLE;
    end else if (w_complete) begin
      r_m_valid <= 1'b0;
      r_state   <= S_IDLE;
    end else begin
      // A grant or rvalid on the timeout edge takes priority over the error.
      unique case (r_state)
        S_REQ: begin
          if (dmem_gnt) begin
            r_state <= w_is_store_m ? S_RESP : S_WAIT;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state   <= S_RESP;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            r_ld_buf <= dmem_rdata;
            r_state  <= S_RESP;
          end else if (w_timeout) begin
            r_state   <= S_RESP;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_m    = w_complete;
  assign inst_m     = r_inst_m;
  assign wb_m       = w_wb;
  assign misalign_m = w_complete && r_misalign;
  assign bus_err_m  = w_complete && r_bus_err;

  assign dmem_req   = (r_state == S_REQ);
  assign dmem_we    = dmem_req && w_is_store_m;
  assign dmem_be    = dmem_req ? w_be_m : 4'b0000;
  assign dmem_addr  = {r_alu_m[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = w_wdata_m;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected write-back results and memory
// requests are queued at issue time and popped by independent monitors.
module tb_mem_stage_lsu;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_x;
  logic        ready_x;
  logic [31:0] PC_x, alu_x, rs2_x, inst_x;
  logic        valid_m;
  logic [31:0] inst_m, wb_m;
  logic        misalign_m, bus_err_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_x    (valid_x),
    .ready_x    (ready_x),
    .PC_x       (PC_x),
    .alu_x      (alu_x),
    .rs2_x      (rs2_x),
    .inst_x     (inst_x),
    .valid_m    (valid_m),
    .inst_m     (inst_m),
    .wb_m       (wb_m),
    .misalign_m (misalign_m),
    .bus_err_m  (bus_err_m),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] wb;
    logic        misalign;
    logic        bus_err;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  resp_t exp_q[$];
  req_t  req_q[$];
  resp_t mon_e;
  req_t  mon_r;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_valid  = 0;
  int    n_pushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_resp(input logic [31:0] inst, input logic [31:0] wb,
                           input logic mis, input logic berr);
    resp_t e;
    e.inst = inst; e.wb = wb; e.misalign = mis; e.bus_err = berr;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  task automatic sync(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [31:0] inst,
                       output int stalls);
    stalls  = 0;
    valid_x = 1'b1;
    PC_x    = pc;
    alu_x   = alu;
    rs2_x   = rs2;
    inst_x  = inst;
    while (1) begin
      @(negedge clk);
      if (ready_x) break;
      stalls++;
      if (stalls > 64) begin
        n_checks++;
        n_errors++;
        $display("FAIL issue_wait: got ready_x low for %0d cycles, want accept", stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_x = 1'b0;
  endtask

  // Write-back monitor.
  always @(negedge clk) begin
    if (rst_n && valid_m) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid_m: got inst 0x%08h wb 0x%08h, want no result", inst_m, wb_m);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_inst", inst_m, mon_e.inst);
        check("resp_wb", wb_m, mon_e.wb);
        check("resp_misalign", {31'b0, misalign_m}, {31'b0, mon_e.misalign});
        check("resp_bus_err", {31'b0, bus_err_m}, {31'b0, mon_e.bus_err});
      end
    end else if (rst_n) begin
      check("qualifiers_idle", {30'b0, misalign_m, bus_err_m}, 32'd0);
    end
  end

  // Memory-request monitor, compares on the grant cycle.
  always @(negedge clk) begin
    if (rst_n && dmem_req && dmem_gnt) begin
      if (req_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_grant: got addr 0x%08h, want no request", dmem_addr);
      end else begin
        mon_r = req_q.pop_front();
        check("req_we", {31'b0, dmem_we}, {31'b0, mon_r.we});
        check("req_addr", dmem_addr, mon_r.addr);
        check("req_be", {28'b0, dmem_be}, {28'b0, mon_r.be});
        if (mon_r.we) check("req_wdata", dmem_wdata, mon_r.wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish within 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int w;
    logic [31:0] ins;
    valid_x = 0; PC_x = 0; alu_x = 0; rs2_x = 0; inst_x = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_valid_m", {31'b0, valid_m}, 32'd0);
    check("rst_ready_x", {31'b0, ready_x}, 32'd1);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_inst_m", inst_m, 32'h0000_0013);
    check("rst_wb_m", wb_m, 32'd0);
    sync(2);
    rst_n = 1'b1;
    sync(1);

    // Three back-to-back ALU ops.
    for (int i = 0; i < 3; i++) begin
      ins = 32'h33 | (32'(i + 1) << 7);
      push_resp(ins, 32'h10, 1'b0, 1'b0);
      issue(32'h100 + 32'(4 * i), 32'h10, 32'h0, ins, st);
      check("add_no_stall", st, 0);
    end

    // LB 0x103, grant two cycles after accept, rvalid one later.
    push_req(1'b0, 32'h100, 4'b1000, 32'h0);
    push_resp(32'h83, 32'hFFFF_FF80, 1'b0, 1'b0);
    issue(32'h200, 32'h103, 32'h0, 32'h83, st);
    sync(1);
    dmem_gnt = 1'b1;
    sync(1);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    sync(1);
    dmem_rvalid = 1'b0;

    // LBU 0x103 with minimum-latency handshake.
    push_req(1'b0, 32'h100, 4'b1000, 32'h0);
    push_resp(32'h4083, 32'h0000_0080, 1'b0, 1'b0);
    issue(32'h204, 32'h103, 32'h0, 32'h4083, st);
    check("lbu_overlap", st, 0);
    dmem_gnt = 1'b1;
    sync(1);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    sync(1);
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("lbu_latency", {31'b0, valid_m}, 32'd1);
    sync(1);

    // SH 0x202 with immediate grant.
    push_req(1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD);
    push_resp(32'h1023, 32'h202, 1'b0, 1'b0);
    issue(32'h208, 32'h202, 32'h1234_ABCD, 32'h1023, st);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("sh_stall_cycle", {31'b0, valid_m}, 32'd0);
    sync(1);
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("sh_valid_next", {31'b0, valid_m}, 32'd1);
    sync(1);

    // Misaligned LW never touches memory.
    push_resp(32'h2083, 32'h301, 1'b1, 1'b0);
    issue(32'h20C, 32'h301, 32'h0, 32'h2083, st);
    @(negedge clk);
    check("lw_mis_noreq", {31'b0, dmem_req}, 32'd0);
    check("lw_mis_valid", {31'b0, valid_m}, 32'd1);
    sync(1);

    // JAL wraps PC+4, JALR follows immediately.
    push_resp(32'h6F, 32'h0, 1'b0, 1'b0);
    issue(32'hFFFF_FFFC, 32'h55, 32'h0, 32'h6F, st);
    push_resp(32'h67, 32'h1004, 1'b0, 1'b0);
    issue(32'h1000, 32'h2000, 32'h0, 32'h67, st);
    check("jump_no_stall", st, 0);

    // SB to byte lane 1.
    push_req(1'b1, 32'h0, 4'b0010, 32'hA5A5_A5A5);
    push_resp(32'h23, 32'h1, 1'b0, 1'b0);
    issue(32'h1004, 32'h1, 32'h77A5, 32'h23, st);
    dmem_gnt = 1'b1;
    sync(1);
    dmem_gnt = 1'b0;

    // LW with no grant: four REQ cycles then bus error.
    push_resp(32'h2083, 32'h400, 1'b0, 1'b1);
    issue(32'h300, 32'h400, 32'h0, 32'h2083, st);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_req_held", {31'b0, dmem_req}, 32'd1);
    end
    @(negedge clk);
    check("to_req_dropped", {31'b0, dmem_req}, 32'd0);
    check("to_valid", {31'b0, valid_m}, 32'd1);
    sync(1);

    // SW granted on the timeout edge: grant wins, no error.
    push_req(1'b1, 32'h404, 4'b1111, 32'hDEAD_BEEF);
    push_resp(32'h2023, 32'h404, 1'b0, 1'b0);
    issue(32'h304, 32'h404, 32'hDEAD_BEEF, 32'h2023, st);
    sync(3);
    dmem_gnt = 1'b1;
    sync(1);
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("late_gnt_valid", {31'b0, valid_m}, 32'd1);
    sync(1);

    // Reset while a load sits in WAIT; a later rvalid must be ignored.
    push_req(1'b0, 32'h500, 4'b1111, 32'h0);
    issue(32'h400, 32'h500, 32'h0, 32'h2083, st);
    dmem_gnt = 1'b1;
    sync(1);
    dmem_gnt = 1'b0;
    sync(1);
    rst_n = 1'b0;
    #1;
    check("rstw_valid_m", {31'b0, valid_m}, 32'd0);
    check("rstw_ready_x", {31'b0, ready_x}, 32'd1);
    check("rstw_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rstw_dmem_we", {31'b0, dmem_we}, 32'd0);
    check("rstw_dmem_be", {28'b0, dmem_be}, 32'd0);
    check("rstw_inst_m", inst_m, 32'h0000_0013);
    check("rstw_wb_m", wb_m, 32'd0);
    check("rstw_flags", {30'b0, misalign_m, bus_err_m}, 32'd0);
    sync(1);
    rst_n = 1'b1;
    sync(1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    sync(1);
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stale_rvalid", {31'b0, valid_m}, 32'd0);
    end
    sync(1);

    // Pipeline still works after the mid-access reset.
    push_resp(32'h33, 32'h99, 1'b0, 1'b0);
    issue(32'h0, 32'h99, 32'h0, 32'h33, st);
    sync(2);

    w = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && w < 20) begin
      @(posedge clk);
      w++;
    end
    check("resp_queue_drained", exp_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    check("valid_m_count", n_valid, n_pushed);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
